// File: rtl/ram8_clr.sv
// 8 x 16-bit register file with a combinational read and an optional clear sweep.
// The clear sweep is built only when RAM8_CLR_SWEEP_EN is defined.
module ram8_clr #(
  parameter logic [15:0] CLR_VAL = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in,
  input  logic        load,
  input  logic [2:0]  address,
  input  logic        clr,
  output logic [15:0] out,
  output logic        busy
);

  logic [15:0] r_word [8];
  logic [7:0]  w_we;
  logic [7:0]  w_clr_we;
  logic        w_accept;

  assign out  = r_word[address];
  assign w_we = w_accept ? (8'b1 << address) : 8'b0;

`ifdef RAM8_CLR_SWEEP_EN

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_ptr;
  logic [2:0] w_ptr_nxt;
  logic       w_sweep_wr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_accept    = 1'b0;
    w_sweep_wr  = 1'b0;
    unique case (r_state)
      IDLE: begin
        // clr wins over load; the simultaneous load is dropped
        if (clr) begin
          w_state_nxt = SWEEP;
          w_ptr_nxt   = 3'd0;
        end else begin
          w_accept = load;
        end
      end
      SWEEP: begin
        w_sweep_wr = 1'b1;
        if (r_ptr == 3'd7) begin
          w_state_nxt = IDLE;
          w_ptr_nxt   = 3'd0;
        end else begin
          w_ptr_nxt = r_ptr + 3'd1;
        end
      end
    endcase
  end

  assign busy     = (r_state == SWEEP);
  assign w_clr_we = w_sweep_wr ? (8'b1 << r_ptr) : 8'b0;

`else

  logic w_unused_clr;

  assign w_unused_clr = clr;
  assign w_accept     = load;
  assign busy         = 1'b0;
  assign w_clr_we     = 8'b0;

`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        r_word[i] <= 16'h0000;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (w_clr_we[i]) begin
          r_word[i] <= CLR_VAL;
        end else if (w_we[i]) begin
          r_word[i] <= in;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram8_clr.sv
// Self-checking bench for ram8_clr: vector table plus hand-written sweep sequences.
// Sweep sequences are exercised when RAM8_CLR_SWEEP_EN is defined.
module tb_ram8_clr;

  logic        clk;
  logic        rst;
  logic [15:0] in;
  logic        load;
  logic [2:0]  address;
  logic        clr;
  logic [15:0] out;
  logic        busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        rst;
    logic        load;
    logic        clr;
    logic [2:0]  addr;
    logic [15:0] din;
    logic [15:0] eout;
    logic        ebusy;
    string       name;
  } vec_t;

  typedef struct {
    logic [15:0] eout;
    logic        ebusy;
    string       name;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  ram8_clr dut (
    .clk    (clk),
    .rst    (rst),
    .in     (in),
    .load   (load),
    .address(address),
    .clr    (clr),
    .out    (out),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic l, input logic c,
                     input logic [2:0] a, input logic [15:0] d,
                     input logic [15:0] eo, input logic eb,
                     input string n);
    vec_t v;
    v.rst = r; v.load = l; v.clr = c; v.addr = a;
    v.din = d; v.eout = eo; v.ebusy = eb; v.name = n;
    tbl.push_back(v);
  endtask

  // Drive one cycle at the falling edge, check out/busy before the rising edge.
  task automatic cyc(input logic r, input logic l, input logic c,
                     input logic [2:0] a, input logic [15:0] d,
                     input logic [15:0] eo, input logic eb,
                     input string n);
    exp_t e;
    @(negedge clk);
    rst = r; load = l; clr = c; address = a; in = d;
    e.eout = eo; e.ebusy = eb; e.name = n;
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    checks++;
    if (out !== e.eout || busy !== e.ebusy) begin
      errors++;
      $display("FAIL %s: got out=%h busy=%b, want out=%h busy=%b",
               e.name, out, busy, e.eout, e.ebusy);
    end
  endtask

  task automatic idle_drive(input logic r, input logic l,
                            input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    rst = r; load = l; clr = 1'b0; address = a; in = d;
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; clr = 1'b0; address = 3'd0; in = 16'h0;
    idle_drive(1'b1, 1'b0, 3'd0, 16'h0);
    idle_drive(1'b1, 1'b1, 3'd2, 16'hDEAD);

    add(0, 0, 0, 3'd0, 16'h0, 16'h0000, 0, "reset_a0");
    add(0, 0, 0, 3'd7, 16'h0, 16'h0000, 0, "reset_a7");
    add(0, 1, 0, 3'd5, 16'h1234, 16'h0000, 0, "wr5_pre");
    add(0, 0, 0, 3'd5, 16'h0, 16'h1234, 0, "wr5_post");
    add(0, 0, 0, 3'd4, 16'h0, 16'h0000, 0, "wr5_a4");
    add(0, 0, 0, 3'd6, 16'h0, 16'h0000, 0, "wr5_a6");
    for (int i = 0; i < 8; i++) begin
      add(0, 1, 0, 3'(i), 16'hA000 + 16'(i),
          (i == 5) ? 16'h1234 : 16'h0000, 0, $sformatf("wrall_pre%0d", i));
    end
    for (int i = 0; i < 8; i++) begin
      add(0, 0, 0, 3'(i), 16'h0, 16'hA000 + 16'(i), 0,
          $sformatf("rdall%0d", i));
    end
    add(1, 1, 0, 3'd3, 16'hBEEF, 16'hA003, 0, "rst_pre");
    add(0, 0, 0, 3'd3, 16'h0, 16'h0000, 0, "rst_a3");
    add(0, 0, 0, 3'd5, 16'h0, 16'h0000, 0, "rst_a5");

    foreach (tbl[k]) begin
      cyc(tbl[k].rst, tbl[k].load, tbl[k].clr, tbl[k].addr, tbl[k].din,
          tbl[k].eout, tbl[k].ebusy, tbl[k].name);
    end

`ifdef RAM8_CLR_SWEEP_EN
    // sweep with blocked load at address 2 and a stray clr mid-sweep
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 0, 3'(i), 16'hFFFF, 16'h0000, 0, "fill_pre");
    end
    cyc(0, 0, 1, 3'd2, 16'h0, 16'hFFFF, 0, "sw_start");
    for (int k = 0; k < 8; k++) begin
      cyc(0, 1, (k == 3), 3'd2, 16'h5555,
          (k > 2) ? 16'h0000 : 16'hFFFF, 1, $sformatf("sw_cyc%0d", k));
    end
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 0, 3'(i), 16'h0, 16'h0000, 0, $sformatf("sw_after%0d", i));
    end

    // clr and load together: clr wins
    cyc(0, 1, 0, 3'd3, 16'h1111, 16'h0000, 0, "cl_prep");
    cyc(0, 1, 1, 3'd3, 16'h0BAD, 16'h1111, 0, "cl_both");
    for (int k = 0; k < 8; k++) begin
      cyc(0, 0, 0, 3'd3, 16'h0,
          (k > 3) ? 16'h0000 : 16'h1111, 1, $sformatf("cl_cyc%0d", k));
    end
    cyc(0, 0, 0, 3'd3, 16'h0, 16'h0000, 0, "cl_after");

    // reset in the fourth sweep cycle
    cyc(0, 1, 0, 3'd6, 16'h6666, 16'h0000, 0, "rs_prep6");
    cyc(0, 1, 0, 3'd7, 16'h7070, 16'h0000, 0, "rs_prep7");
    cyc(0, 0, 1, 3'd6, 16'h0, 16'h6666, 0, "rs_start");
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 0, 3'd6, 16'h0, 16'h6666, 1, $sformatf("rs_cyc%0d", k));
    end
    cyc(1, 0, 0, 3'd6, 16'h0, 16'h6666, 1, "rs_assert");
    cyc(0, 1, 0, 3'd7, 16'h7777, 16'h0000, 0, "rs_idle7");
    cyc(0, 0, 0, 3'd7, 16'h0, 16'h7777, 0, "rs_load7");
    cyc(0, 0, 0, 3'd6, 16'h0, 16'h0000, 0, "rs_a6");
    cyc(0, 0, 0, 3'd7, 16'h0, 16'h7777, 0, "rs_busy_idle");
`else
    // clr has no effect: load is taken and busy stays low
    cyc(0, 1, 1, 3'd1, 16'h00FF, 16'h0000, 0, "off_both");
    cyc(0, 0, 1, 3'd1, 16'h0, 16'h00FF, 0, "off_a1");
    cyc(0, 1, 1, 3'd2, 16'h0222, 16'h0000, 0, "off_a2pre");
    cyc(0, 0, 0, 3'd2, 16'h0, 16'h0222, 0, "off_a2");
    cyc(0, 0, 0, 3'd1, 16'h0, 16'h00FF, 0, "off_a1b");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram8_clr.md
RAM8_CLR -- requirements
Module: ram8_clr

Interface
REQ-001 SHALL have parameter CLR_VAL, default 16'h0000, the word value written by a clear sweep.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-004 SHALL have port in, input, 16, the write data.
REQ-005 SHALL have port load, input, 1, the write request for word[address].
REQ-006 SHALL have port address, input, 3, the word select for read and write.
REQ-007 SHALL have port clr, input, 1, the clear-sweep request.
REQ-008 SHALL have port out, output, 16, the read data, equal to word[address].
REQ-009 SHALL have port busy, output, 1, high while a clear sweep is in progress.

Function
REQ-010 SHALL hold 8 words of 16 bits each, word[0..7].
REQ-011 SHALL drive out combinationally from the current word[address], with zero read latency.
REQ-012 SHALL show the pre-write value on out during a write cycle; the new value appears after the edge.
REQ-013 SHALL accept a write in IDLE with load=1 and clr=0: at the edge, word[address] <= in and no other word changes.
REQ-014 SHALL one-hot decode the write enable from address, so exactly one word is written per accepted load.
REQ-015 SHALL implement a state machine with states IDLE and SWEEP, plus a 3-bit pointer ptr.
REQ-016 SHALL go from IDLE with clr=1 at an edge to SWEEP, with ptr <= 0; no word is written on that edge.
REQ-017 SHALL, in SWEEP, at each edge write word[ptr] <= CLR_VAL and set ptr <= ptr+1.
REQ-018 SHALL, in SWEEP with ptr=7, write word[7], return to IDLE and set ptr <= 0; ptr never wraps past 7 within a sweep.
REQ-019 SHALL make a sweep last exactly 8 cycles in SWEEP, with busy=1 for exactly those 8 cycles.
REQ-020 SHALL give clr priority over load when both are 1 in IDLE; that load is dropped.
REQ-021 SHALL ignore load while in SWEEP: dropped, not queued, with no effect on any word.
REQ-022 SHALL ignore clr while in SWEEP: no restart and no extension.
REQ-023 SHALL keep reads legal during SWEEP: out shows CLR_VAL for words already swept and old contents for the rest.
REQ-024 SHALL derive busy from registered state only, with no combinational path from clr.

Reset
REQ-025 SHALL, when rst=1 at an edge, set all words to 16'h0000, state to IDLE, ptr to 0 and busy to 0.
REQ-026 SHALL give rst priority over load, clr and an in-progress sweep; rst mid-sweep aborts the sweep.
REQ-027 SHALL make out after reset equal 16'h0000 for every address.

Configuration
REQ-028 SHALL compile in the clear sweep (REQ-015..REQ-024) only when macro RAM8_CLR_SWEEP_EN is defined.
REQ-029 SHALL, without RAM8_CLR_SWEEP_EN, ignore clr, tie busy to 0, omit the state machine and ptr, and accept load every cycle.

Verification
REQ-030 SHALL cover reset then write: rst pulse, then write 16'h1234 to address 5 -> out=0 at addr 5 before the edge, 16'h1234 after; other addresses read 0.
REQ-031 SHALL cover write all then read: write 16'hA000+i to address i for i=0..7, then read 0..7 -> out=16'hA000..16'hA007, with one word changed per write.
REQ-032 SHALL cover a sweep with blocked load: fill all words with 16'hFFFF, pulse clr, assert load address 2 with in=16'h5555 during SWEEP -> busy high for 8 cycles, all words = CLR_VAL after, and address 2 is not 16'h5555.
REQ-033 SHALL cover clr and load in the same cycle: in IDLE, clr=1 and load=1 at address 3 with in=16'h0BAD -> sweep starts and word[3] ends at CLR_VAL.
REQ-034 SHALL cover rst mid-sweep: assert rst in sweep cycle 4 -> busy=0 next cycle, all words 0, state IDLE, and the next load is accepted.
REQ-035 SHALL cover the macro-off build: without RAM8_CLR_SWEEP_EN, clr=1 with load=1 at address 1 and in=16'h00FF -> word[1]=16'h00FF and busy stays 0.
